// File: rtl/signal_capture_pkg.sv
// Shared types and defaults for the signal capture block.
package signal_capture_pkg;

    localparam int NB_DATA_DEF = 16;
    localparam int NB_ADDR_DEF = 10;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_READ    = 2'd3
    } state_t;

    function automatic int depth_of(input int nb_addr);
        return 1 << nb_addr;
    endfunction

endpackage

// File: rtl/signal_capture_ram.sv
// Simple dual-port sample RAM: synchronous write, synchronous read, no reset.
module capture_ram
    import signal_capture_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic               i_clock,
    input  logic               wr_en_i,
    input  logic [NB_ADDR-1:0] wr_addr_i,
    input  logic [NB_DATA-1:0] wr_data_i,
    input  logic               rd_en_i,
    input  logic [NB_ADDR-1:0] rd_addr_i,
    output logic [NB_DATA-1:0] rd_data_o
);

    localparam int DEPTH = depth_of(NB_ADDR);

    logic [NB_DATA-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge i_clock) begin
        if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
        if (rd_en_i) rd_data_o <= mem_q[rd_addr_i];
    end

endmodule

// File: rtl/signal_capture.sv
// Captures DEPTH consecutive samples (immediately or on a rising level crossing)
// and streams them out over valid/ready. States: IDLE | ARMED (wait crossing) | CAPTURE | READ
module signal_capture
    import signal_capture_pkg::*;
#(
    parameter int NB_DATA = NB_DATA_DEF,
    parameter int NB_ADDR = NB_ADDR_DEF
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic [NB_DATA-1:0] i_sample,
    input  logic               i_arm,
    input  logic               i_trig_en,
    input  logic [NB_DATA-1:0] i_trig_level,
    output logic               o_busy,
    output logic               o_done,
    output logic [NB_DATA-1:0] o_rd_data,
    output logic               o_rd_valid,
    input  logic               i_rd_ready,
    output logic               o_rd_last
);

    state_t state_q, state_d;
    logic [NB_ADDR-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic rd_all_q, rd_all_d, prev_vld_q, prev_vld_d, arm_ok_q;
    logic signed [NB_DATA-1:0] prev_q, prev_d, level_q, level_d, sample_s;
    logic ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
    logic [NB_DATA-1:0] skid_data_q, skid_data_d, out_data_q, out_data_d, ram_rd_data;
    logic skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
    logic out_vld_q, out_vld_d, out_last_q, out_last_d;
    logic done_q, done_d, busy_q;
    logic wr_en, rd_en, trig, pop;
    logic [NB_ADDR-1:0] wr_addr;
    logic [1:0] occ;

    assign sample_s = i_sample;
    assign trig     = prev_vld_q && (prev_q < level_q) && (sample_s >= level_q);
    assign pop      = out_vld_q && i_rd_ready;
    // Entries held or in flight after this cycle's pop; issue only while room remains.
    assign occ      = {1'b0, out_vld_q} + {1'b0, skid_vld_q} + {1'b0, ram_vld_q} - {1'b0, pop};
    assign rd_en    = (state_q == ST_READ) && !rd_all_q && (occ < 2'd2);

    capture_ram #(.NB_DATA(NB_DATA), .NB_ADDR(NB_ADDR)) u_ram (
        .i_clock   (i_clock),
        .wr_en_i   (wr_en),
        .wr_addr_i (wr_addr),
        .wr_data_i (i_sample),
        .rd_en_i   (rd_en),
        .rd_addr_i (rd_ptr_q),
        .rd_data_o (ram_rd_data)
    );

    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        rd_all_d    = rd_all_q;
        prev_d      = prev_q;
        prev_vld_d  = prev_vld_q;
        level_d     = level_q;
        ram_vld_d   = 1'b0;
        ram_last_d  = 1'b0;
        skid_data_d = skid_data_q;
        skid_vld_d  = skid_vld_q;
        skid_last_d = skid_last_q;
        out_data_d  = out_data_q;
        out_vld_d   = out_vld_q;
        out_last_d  = out_last_q;
        done_d      = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = wr_ptr_q;
        case (state_q)
            ST_IDLE: begin
                if (i_arm && arm_ok_q) begin
                    level_d    = i_trig_level;
                    prev_vld_d = 1'b0;
                    wr_ptr_d   = '0;
                    state_d    = i_trig_en ? ST_ARMED : ST_CAPTURE;
                end
            end
            ST_ARMED: begin
                if (trig) begin
                    wr_en    = 1'b1;
                    wr_addr  = '0;
                    wr_ptr_d = NB_ADDR'(1);
                    state_d  = ST_CAPTURE;
                end else begin
                    prev_d     = sample_s;
                    prev_vld_d = 1'b1;
                end
            end
            ST_CAPTURE: begin
                wr_en    = 1'b1;
                wr_ptr_d = wr_ptr_q + NB_ADDR'(1);
                if (&wr_ptr_q) begin
                    state_d  = ST_READ;
                    rd_ptr_d = '0;
                    rd_all_d = 1'b0;
                end
            end
            ST_READ: begin
                if (rd_en) begin
                    ram_vld_d  = 1'b1;
                    ram_last_d = &rd_ptr_q;
                    rd_ptr_d   = rd_ptr_q + NB_ADDR'(1);
                    if (&rd_ptr_q) rd_all_d = 1'b1;
                end
                // Output register refills from the skid first so order is preserved.
                if (!out_vld_q || pop) begin
                    if (skid_vld_q) begin
                        out_data_d  = skid_data_q;
                        out_last_d  = skid_last_q;
                        out_vld_d   = 1'b1;
                        skid_vld_d  = ram_vld_q;
                        skid_data_d = ram_rd_data;
                        skid_last_d = ram_last_q;
                    end else if (ram_vld_q) begin
                        out_data_d  = ram_rd_data;
                        out_last_d  = ram_last_q;
                        out_vld_d   = 1'b1;
                    end else begin
                        out_vld_d   = 1'b0;
                    end
                end else if (ram_vld_q) begin
                    skid_data_d = ram_rd_data;
                    skid_last_d = ram_last_q;
                    skid_vld_d  = 1'b1;
                end
                if (pop && out_last_q) begin
                    state_d    = ST_IDLE;
                    done_d     = 1'b1;
                    out_vld_d  = 1'b0;
                    out_last_d = 1'b0;
                    skid_vld_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            rd_all_q    <= 1'b0;
            prev_q      <= '0;
            prev_vld_q  <= 1'b0;
            level_q     <= '0;
            arm_ok_q    <= 1'b0;
            ram_vld_q   <= 1'b0;
            ram_last_q  <= 1'b0;
            skid_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_last_q <= 1'b0;
            out_data_q  <= '0;
            out_vld_q   <= 1'b0;
            out_last_q  <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            rd_all_q    <= rd_all_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            level_q     <= level_d;
            arm_ok_q    <= 1'b1;
            ram_vld_q   <= ram_vld_d;
            ram_last_q  <= ram_last_d;
            skid_data_q <= skid_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_last_q <= skid_last_d;
            out_data_q  <= out_data_d;
            out_vld_q   <= out_vld_d;
            out_last_q  <= out_last_d;
            done_q      <= done_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    assign o_busy     = busy_q;
    assign o_done     = done_q;
    assign o_rd_data  = out_data_q;
    assign o_rd_valid = out_vld_q;
    assign o_rd_last  = out_last_q;

endmodule

// File: tb/tb_signal_capture.sv
// Bench for signal_capture: logs every driven sample and derives the expected window from it.
module tb_signal_capture;

    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic i_reset = 1'b0;
    logic signed [15:0] i_sample = '0;
    logic i_arm = 1'b0, i_trig_en = 1'b0, i_rd_ready = 1'b1;
    logic signed [15:0] i_trig_level = '0;
    logic o_busy, o_done, o_rd_valid, o_rd_last;
    logic [15:0] o_rd_data;

    signal_capture #(.NB_DATA(16), .NB_ADDR(10)) dut (
        .i_clock(clk), .i_reset(i_reset), .i_sample(i_sample), .i_arm(i_arm),
        .i_trig_en(i_trig_en), .i_trig_level(i_trig_level), .o_busy(o_busy),
        .o_done(o_done), .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid),
        .i_rd_ready(i_rd_ready), .o_rd_last(o_rd_last)
    );

    always #5 clk = ~clk;

    int n_vec = 0, n_err = 0;
    int cyc = 0, arm_cyc = 0;
    int gen_mode = 0;
    logic signed [15:0] const_val = '0;
    logic signed [15:0] hist [0:65535];

    logic signed [15:0] rx_d[$];
    bit rx_l[$];
    int done_cnt, stall_err, first_vcyc, last_cyc, extra_valid;
    bit post_valid, post_done, post_busy, timed_out, arm_spam = 1'b0;

    function automatic logic signed [15:0] gen(input int c);
        int v;
        case (gen_mode)
            0: return 16'(c);
            1: return 16'(int'(1000.0 * $sin(6.283185307 * real'(c) / 37.0)));
            2: return 16'($urandom);
            3: return const_val;
            default: begin
                if ($urandom_range(0, 5) == 0) return 16'sd32767;
                v = int'($urandom_range(0, 65534)) - 32768;
                return 16'(v);
            end
        endcase
    endfunction

    // Sample for interval n is applied just after posedge n and logged in hist[n].
    initial begin
        logic signed [15:0] s;
        hist[0] = '0;
        forever begin
            @(posedge clk); #1;
            cyc++;
            if (cyc > 60000) begin
                $display("FAIL cycle_limit: got %0d cycles, want under 60000", cyc);
                $fatal(1);
            end
            s = gen(cyc);
            i_sample = s;
            hist[cyc] = s;
        end
    end

    // First index c >= arm+2 where the logged stream crosses lvl upward; -1 if none.
    function automatic int find_trig(input int a, input logic signed [15:0] lvl);
        for (int c = a + 2; c <= cyc; c++)
            if (hist[c-1] < lvl && hist[c] >= lvl) return c;
        return -1;
    endfunction

    task automatic arm(input bit te, input logic signed [15:0] lvl);
        @(posedge clk); #2;
        i_arm = 1'b1; i_trig_en = te; i_trig_level = lvl; arm_cyc = cyc;
        @(posedge clk); #2;
        i_arm = 1'b0;
    endtask

    task automatic collect(input bit bp, input int budget);
        bit pv, pr, pl, fin;
        logic [15:0] pd;
        int k, extra;
        rx_d.delete(); rx_l.delete();
        done_cnt = 0; stall_err = 0; first_vcyc = -1; last_cyc = -1; extra_valid = 0;
        timed_out = 0; post_valid = 0; post_done = 0; post_busy = 0;
        pv = 0; pr = 0; pd = '0; pl = 0; fin = 0; k = 0; extra = 0;
        while (1) begin
            @(posedge clk); #2;
            k++;
            if (o_done) done_cnt++;
            if (pv && !pr && (o_rd_valid !== 1'b1 || o_rd_data !== pd || o_rd_last !== pl)) stall_err++;
            if (fin) begin
                extra++;
                if (extra == 1) begin post_valid = o_rd_valid; post_done = o_done; post_busy = o_busy; end
                if (o_rd_valid) extra_valid++;
                if (extra >= 4) break;
            end else begin
                if (o_rd_valid && first_vcyc < 0) first_vcyc = cyc;
                i_rd_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
                if (arm_spam) i_arm = ($urandom_range(0, 3) == 0);
                if (o_rd_valid && i_rd_ready) begin
                    rx_d.push_back(o_rd_data);
                    rx_l.push_back(o_rd_last);
                    if (rx_d.size() == DEPTH) begin fin = 1; last_cyc = cyc; i_arm = 1'b0; end
                end
                pv = o_rd_valid; pr = i_rd_ready; pd = o_rd_data; pl = o_rd_last;
            end
            if (k > budget) begin timed_out = 1; break; end
        end
        i_arm = 1'b0; i_rd_ready = 1'b1;
    endtask

    task automatic test_reset;
        #3 i_reset = 1'b1;
        #1;
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", o_busy); end
        n_vec++; if (o_done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", o_done); end
        n_vec++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", o_rd_valid); end
        n_vec++; if (o_rd_last !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b want 0", o_rd_last); end
        n_vec++; if (o_rd_data !== 16'h0) begin n_err++; $display("FAIL reset_data: got %h want 0", o_rd_data); end
        repeat (3) @(posedge clk);
        #2 i_reset = 1'b0;
        repeat (3) @(posedge clk);
    endtask

    task automatic test_immediate;
        int base, nl;
        gen_mode = 0;
        arm(1'b0, 16'sd0);
        base = arm_cyc + 1;
        collect(1'b0, 6000);
        n_vec++; if (timed_out !== 1'b0) begin n_err++; $display("FAIL imm_timeout: got %0d beats want %0d", rx_d.size(), DEPTH); end
        n_vec++; if (rx_d.size() !== DEPTH) begin n_err++; $display("FAIL imm_count: got %0d want %0d", rx_d.size(), DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (i >= rx_d.size() || rx_d[i] !== hist[base+i]) begin
                n_err++; $display("FAIL imm_beat %0d: got %0d want %0d", i, (i < rx_d.size()) ? rx_d[i] : 16'sd0, hist[base+i]);
            end
        end
        nl = 0;
        foreach (rx_l[i]) nl += int'(rx_l[i]);
        n_vec++; if (nl !== 1) begin n_err++; $display("FAIL imm_last_count: got %0d want 1", nl); end
        n_vec++; if (rx_l.size() == DEPTH && rx_l[DEPTH-1] !== 1'b1) begin n_err++; $display("FAIL imm_last_pos: got 0 want 1"); end
        n_vec++; if (first_vcyc !== arm_cyc + 1027) begin n_err++; $display("FAIL imm_latency: got %0d want %0d", first_vcyc, arm_cyc + 1027); end
        n_vec++; if (last_cyc !== arm_cyc + 2050) begin n_err++; $display("FAIL imm_throughput: got %0d want %0d", last_cyc, arm_cyc + 2050); end
        n_vec++; if (post_valid !== 1'b0) begin n_err++; $display("FAIL imm_post_valid: got %b want 0", post_valid); end
        n_vec++; if (post_done !== 1'b1) begin n_err++; $display("FAIL imm_post_done: got %b want 1", post_done); end
        n_vec++; if (post_busy !== 1'b0) begin n_err++; $display("FAIL imm_post_busy: got %b want 0", post_busy); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL imm_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_trigger;
        int c, bad;
        gen_mode = 3; const_val = -16'sd500;
        arm(1'b1, 16'sd0);
        bad = 0;
        repeat (40) begin
            @(posedge clk); #2;
            if (o_busy !== 1'b1 || o_rd_valid !== 1'b0) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL trig_armed_hold: got %0d bad cycles want 0", bad); end
        gen_mode = 1;
        collect(1'b0, 6000);
        c = find_trig(arm_cyc, 16'sd0);
        n_vec++; if (c < 0 || rx_d.size() !== DEPTH) begin n_err++; $display("FAIL trig_window: got %0d beats (trigger idx %0d) want %0d", rx_d.size(), c, DEPTH); end
        else for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (rx_d[i] !== hist[c+i]) begin n_err++; $display("FAIL trig_beat %0d: got %0d want %0d", i, rx_d[i], hist[c+i]); end
        end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL trig_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_backpressure;
        int base, nl;
        gen_mode = 2;
        arm(1'b0, 16'sd0);
        base = arm_cyc + 1;
        collect(1'b1, 9000);
        n_vec++; if (rx_d.size() !== DEPTH) begin n_err++; $display("FAIL bp_count: got %0d want %0d", rx_d.size(), DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (i >= rx_d.size() || rx_d[i] !== hist[base+i]) begin
                n_err++; $display("FAIL bp_beat %0d: got %0d want %0d", i, (i < rx_d.size()) ? rx_d[i] : 16'sd0, hist[base+i]);
            end
        end
        nl = 0;
        foreach (rx_l[i]) nl += int'(rx_l[i]);
        n_vec++; if (nl !== 1 || rx_l.size() !== DEPTH || rx_l[rx_l.size()-1] !== 1'b1) begin n_err++; $display("FAIL bp_last: got %0d last flags want 1 on final beat", nl); end
        n_vec++; if (stall_err !== 0) begin n_err++; $display("FAIL bp_stall_stable: got %0d unstable stalls want 0", stall_err); end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL bp_done_count: got %0d want 1", done_cnt); end
        n_vec++; if (post_valid !== 1'b0) begin n_err++; $display("FAIL bp_post_valid: got %b want 0", post_valid); end
    endtask

    task automatic test_reset_mid;
        int bad, base;
        gen_mode = 2;
        arm(1'b0, 16'sd0);
        repeat (500) @(posedge clk);
        #2 i_reset = 1'b1;
        #1;
        n_vec++; if (o_busy !== 1'b0) begin n_err++; $display("FAIL mid_busy: got %b want 0", o_busy); end
        n_vec++; if (o_rd_valid !== 1'b0) begin n_err++; $display("FAIL mid_valid: got %b want 0", o_rd_valid); end
        repeat (3) @(posedge clk);
        #2 i_reset = 1'b0;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #2;
            if (o_busy !== 1'b0 || o_rd_valid !== 1'b0 || o_done !== 1'b0) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL mid_quiet: got %0d active cycles want 0", bad); end
        arm(1'b0, 16'sd0);
        base = arm_cyc + 1;
        collect(1'b0, 6000);
        n_vec++; if (rx_d.size() !== DEPTH) begin n_err++; $display("FAIL mid_rearm_count: got %0d want %0d", rx_d.size(), DEPTH); end
        for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (i >= rx_d.size() || rx_d[i] !== hist[base+i]) begin
                n_err++; $display("FAIL mid_beat %0d: got %0d want %0d", i, (i < rx_d.size()) ? rx_d[i] : 16'sd0, hist[base+i]);
            end
        end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL mid_done_count: got %0d want 1", done_cnt); end
    endtask

    task automatic test_arm_ignore;
        int a0, c, bad;
        gen_mode = 3; const_val = -16'sd500;
        arm(1'b1, 16'sd0);
        a0 = arm_cyc;
        repeat (20) begin
            @(posedge clk); #2;
            i_arm = 1'($urandom_range(0, 1));
            i_trig_en = 1'b0;
        end
        i_arm = 1'b0;
        gen_mode = 1;
        arm_spam = 1'b1;
        collect(1'b0, 6000);
        arm_spam = 1'b0;
        c = find_trig(a0, 16'sd0);
        n_vec++; if (c < 0 || rx_d.size() !== DEPTH) begin n_err++; $display("FAIL ign_window: got %0d beats (trigger idx %0d) want %0d", rx_d.size(), c, DEPTH); end
        else for (int i = 0; i < DEPTH; i++) begin
            n_vec++;
            if (rx_d[i] !== hist[c+i]) begin n_err++; $display("FAIL ign_beat %0d: got %0d want %0d", i, rx_d[i], hist[c+i]); end
        end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL ign_done_count: got %0d want 1", done_cnt); end
        bad = extra_valid;
        repeat (40) begin
            @(posedge clk); #2;
            if (o_busy !== 1'b0 || o_rd_valid !== 1'b0) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL ign_second_window: got %0d active cycles want 0", bad); end
    endtask

    task automatic test_boundary;
        int bad, c;
        gen_mode = 2;
        arm(1'b1, -16'sd32768);
        bad = 0;
        repeat (300) begin
            @(posedge clk); #2;
            if (o_busy !== 1'b1 || o_rd_valid !== 1'b0) bad++;
        end
        n_vec++; if (bad !== 0) begin n_err++; $display("FAIL bnd_min_level: got %0d non-armed cycles want 0", bad); end
        #1 i_reset = 1'b1;
        repeat (2) @(posedge clk);
        #2 i_reset = 1'b0;
        repeat (3) @(posedge clk);
        gen_mode = 4;
        arm(1'b1, 16'sd32767);
        collect(1'b0, 6000);
        c = find_trig(arm_cyc, 16'sd32767);
        n_vec++; if (c < 0 || rx_d.size() !== DEPTH) begin n_err++; $display("FAIL bnd_max_window: got %0d beats (trigger idx %0d) want %0d", rx_d.size(), c, DEPTH); end
        else begin
            n_vec++; if (rx_d[0] !== 16'sd32767) begin n_err++; $display("FAIL bnd_max_first: got %0d want 32767", rx_d[0]); end
            for (int i = 0; i < DEPTH; i++) begin
                n_vec++;
                if (rx_d[i] !== hist[c+i]) begin n_err++; $display("FAIL bnd_beat %0d: got %0d want %0d", i, rx_d[i], hist[c+i]); end
            end
        end
        n_vec++; if (done_cnt !== 1) begin n_err++; $display("FAIL bnd_done_count: got %0d want 1", done_cnt); end
    endtask

    initial begin
        test_reset();
        test_immediate();
        test_trigger();
        test_backpressure();
        test_reset_mid();
        test_arm_ignore();
        test_boundary();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
